// File: rtl/reg_xfer_pkg.sv
// Shared definitions for the register-transfer sequencer.
// REG_XFER_SWAP_EN enables the SWAP command in reg_xfer_ctrl.
package reg_xfer_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int IDX_W_DEF  = 4;

    typedef enum logic [1:0] {
        OP_MOV  = 2'b00,
        OP_LDI  = 2'b01,
        OP_RD   = 2'b10,
        OP_SWAP = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD_A  = 4'd1,
        S_CAP_A = 4'd2,
        S_RD_B  = 4'd3,
        S_CAP_B = 4'd4,
        S_DRV   = 4'd5,
        S_WR    = 4'd6,
        S_DRV2  = 4'd7,
        S_WR2   = 4'd8
    } state_t;

endpackage

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer between command source, register file and bus.
// Macro REG_XFER_SWAP_EN: when defined, op 11 swaps two registers.
module reg_xfer_ctrl
    import reg_xfer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_src,
    input  logic [IDX_W-1:0]  cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [IDX_W-1:0]  index,
    output logic              rEn,
    output logic              wEn,
    output logic [DATA_W-1:0] busVal,
    output logic              loadBus,
    input  logic [DATA_W-1:0] bus_in,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rd_data
);

    state_t              state_q;
    state_t              state_d;
    op_t                 op_q;
    logic [IDX_W-1:0]    src_q;
    logic [IDX_W-1:0]    dst_q;
    logic [DATA_W-1:0]   tmp_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                done_q;
    logic                done_d;
    logic                err_q;
    logic                err_d;
    logic                accept;
    logic [IDX_W-1:0]    drv_idx;
    logic [DATA_W-1:0]   drv_val;

    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_data   = rd_data_q;

`ifdef REG_XFER_SWAP_EN
    logic [DATA_W-1:0]   tmp2_q;

    // Second holding register: destination value during SWAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmp2_q <= '0;
        end else if (state_q == S_CAP_B) begin
            tmp2_q <= bus_in;
        end
    end

    // First write of a SWAP puts the dst value into src.
    assign drv_idx = (op_q == OP_SWAP) ? src_q  : dst_q;
    assign drv_val = (op_q == OP_SWAP) ? tmp2_q : tmp_q;
`else
    assign drv_idx = dst_q;
    assign drv_val = tmp_q;
`endif

    // State register plus the registered completion flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Command latch and bus capture; LDI immediate rides in tmp.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= OP_MOV;
            src_q     <= '0;
            dst_q     <= '0;
            tmp_q     <= '0;
            rd_data_q <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_t'(cmd_op);
                src_q <= cmd_src;
                dst_q <= cmd_dst;
                tmp_q <= cmd_imm;
            end
            if (state_q == S_CAP_A) begin
                if (op_q == OP_RD) begin
                    rd_data_q <= bus_in;
                end else begin
                    tmp_q <= bus_in;
                end
            end
        end
    end

    // Next-state sequencing; done is raised on the way back to IDLE.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (op_t'(cmd_op))
                        OP_MOV:  state_d = S_RD_A;
                        OP_RD:   state_d = S_RD_A;
                        OP_LDI:  state_d = S_DRV;
                        OP_SWAP: begin
`ifdef REG_XFER_SWAP_EN
                            state_d = S_RD_A;
`else
                            done_d = 1'b1;
                            err_d  = 1'b1;
`endif
                        end
                    endcase
                end
            end
            S_RD_A: state_d = S_CAP_A;
            S_CAP_A: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q == OP_MOV) begin
                    state_d = S_DRV;
                    done_d  = 1'b0;
                end
`ifdef REG_XFER_SWAP_EN
                if (op_q == OP_SWAP) begin
                    state_d = S_RD_B;
                    done_d  = 1'b0;
                end
`endif
            end
`ifdef REG_XFER_SWAP_EN
            S_RD_B:  state_d = S_CAP_B;
            S_CAP_B: state_d = S_DRV;
`endif
            S_DRV: state_d = S_WR;
            S_WR: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
`ifdef REG_XFER_SWAP_EN
                if (op_q == OP_SWAP) begin
                    state_d = S_DRV2;
                    done_d  = 1'b0;
                end
`endif
            end
`ifdef REG_XFER_SWAP_EN
            S_DRV2: state_d = S_WR2;
            S_WR2: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Register-file and bus-driver controls decoded from state.
    always_comb begin
        index   = '0;
        rEn     = 1'b0;
        wEn     = 1'b0;
        loadBus = 1'b0;
        busVal  = '0;
        unique case (state_q)
            S_RD_A: begin
                index = src_q;
                rEn   = 1'b1;
            end
            S_CAP_A: index = src_q;
`ifdef REG_XFER_SWAP_EN
            S_RD_B: begin
                index = dst_q;
                rEn   = 1'b1;
            end
            S_CAP_B: index = dst_q;
`endif
            S_DRV: begin
                index   = drv_idx;
                busVal  = drv_val;
                loadBus = 1'b1;
            end
            S_WR: begin
                index   = drv_idx;
                busVal  = drv_val;
                loadBus = 1'b1;
                wEn     = 1'b1;
            end
`ifdef REG_XFER_SWAP_EN
            S_DRV2: begin
                index   = dst_q;
                busVal  = tmp_q;
                loadBus = 1'b1;
            end
            S_WR2: begin
                index   = dst_q;
                busVal  = tmp_q;
                loadBus = 1'b1;
                wEn     = 1'b1;
            end
`endif
            default: index = '0;
        endcase
    end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench for reg_xfer_ctrl with a behavioural register file.
// Expectations follow REG_XFER_SWAP_EN when it is defined.
module tb_reg_xfer_ctrl;
    import reg_xfer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_src;
    logic [3:0]  cmd_dst;
    logic [15:0] cmd_imm;
    logic [3:0]  index;
    logic        rEn;
    logic        wEn;
    logic [15:0] busVal;
    logic        loadBus;
    logic [15:0] bus;
    logic        done;
    logic        err;
    logic [15:0] rd_data;

    int checks = 0;
    int failures = 0;

    reg_xfer_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src),
        .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .index(index), .rEn(rEn), .wEn(wEn),
        .busVal(busVal), .loadBus(loadBus),
        .bus_in(bus), .done(done), .err(err),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural register file with registered read onto the bus.
    logic [15:0] rf [16] = '{default: 16'h0};
    logic [15:0] rf_out = 16'h0;
    always @(posedge clk) begin
        if (rEn) rf_out <= rf[index];
        if (wEn) rf[index] <= bus;
    end
    assign bus = loadBus ? busVal : rf_out;

    // Invariant monitor plus write/done counters.
    int wen_cnt = 0;
    int done_cnt = 0;
    int mon_viol = 0;
    logic        p_load = 1'b0;
    logic        p_wen = 1'b0;
    logic [3:0]  p_idx = 4'h0;
    logic [15:0] p_val = 16'h0;
    always @(negedge clk) begin
        if (wEn) wen_cnt <= wen_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if ((rEn && wEn) || (rEn && loadBus) || (wEn && !loadBus)) begin
            mon_viol <= mon_viol + 1;
            $display("FAIL invariant rEn=%b wEn=%b loadBus=%b required exclusive",
                     rEn, wEn, loadBus);
        end
        if (wEn && !(p_load && !p_wen && p_idx == index && p_val == busVal)) begin
            mon_viol <= mon_viol + 1;
            $display("FAIL drv_wr_pair index=%0h busVal=%0h required %0h/%0h",
                     index, busVal, p_idx, p_val);
        end
        p_load <= loadBus;
        p_wen  <= wEn;
        p_idx  <= index;
        p_val  <= busVal;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: register contents and last RD value.
    logic [15:0] m [16] = '{default: 16'h0};
    logic [15:0] m_rd = 16'h0;

    task automatic model(input logic [1:0] op, input logic [3:0] s,
                         input logic [3:0] d, input logic [15:0] imm,
                         output int lat, output logic e,
                         output logic [15:0] rv);
        logic [15:0] t;
        e = 1'b0;
        lat = 3;
        case (op)
            2'b00: begin m[d] = m[s]; lat = 5; end
            2'b01: m[d] = imm;
            2'b10: m_rd = m[s];
            default: begin
`ifdef REG_XFER_SWAP_EN
                t = m[s]; m[s] = m[d]; m[d] = t; lat = 9;
`else
                t = 16'h0; lat = 1; e = 1'b1;
`endif
            end
        endcase
        rv = m_rd;
    endtask

    // Issue one command from a negedge, return latency seen at done.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] s,
                           input logic [3:0] d, input logic [15:0] imm,
                           output int lat, output logic e,
                           output logic [15:0] rv);
        int g;
        cmd_op = op; cmd_src = s; cmd_dst = d; cmd_imm = imm;
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        e = err;
        rv = rd_data;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [15:0] imm;
        int          lat;
        logic        err;
        logic        chk_rd;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int lat, mlat;
        logic e, me;
        logic [15:0] rv, mrv;
        int w0, d0;
        int swl;
        logic swe;
        logic [15:0] r2, r7;

`ifdef REG_XFER_SWAP_EN
        swl = 9; swe = 1'b0; r2 = 16'h5500; r7 = 16'h00AA;
`else
        swl = 1; swe = 1'b1; r2 = 16'h00AA; r7 = 16'h5500;
`endif
        tbl[0]  = '{OP_LDI,  4'd0, 4'd1, 16'h1234, 3, 1'b0, 1'b0, 16'h0};
        tbl[1]  = '{OP_MOV,  4'd1, 4'd5, 16'h0,    5, 1'b0, 1'b0, 16'h0};
        tbl[2]  = '{OP_RD,   4'd5, 4'd0, 16'h0,    3, 1'b0, 1'b1, 16'h1234};
        tbl[3]  = '{OP_LDI,  4'd0, 4'd2, 16'h00AA, 3, 1'b0, 1'b0, 16'h0};
        tbl[4]  = '{OP_LDI,  4'd0, 4'd7, 16'h5500, 3, 1'b0, 1'b0, 16'h0};
        tbl[5]  = '{OP_SWAP, 4'd2, 4'd7, 16'h0,    swl, swe, 1'b0, 16'h0};
        tbl[6]  = '{OP_RD,   4'd2, 4'd0, 16'h0,    3, 1'b0, 1'b1, r2};
        tbl[7]  = '{OP_RD,   4'd7, 4'd0, 16'h0,    3, 1'b0, 1'b1, r7};
        tbl[8]  = '{OP_MOV,  4'd5, 4'd5, 16'h0,    5, 1'b0, 1'b0, 16'h0};
        tbl[9]  = '{OP_RD,   4'd5, 4'd0, 16'h0,    3, 1'b0, 1'b1, 16'h1234};
        tbl[10] = '{OP_SWAP, 4'd3, 4'd3, 16'h0,    swl, swe, 1'b0, 16'h0};
        tbl[11] = '{OP_RD,   4'd3, 4'd0, 16'h0,    3, 1'b0, 1'b1, 16'd20};

        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00; cmd_src = 4'h0; cmd_dst = 4'h0; cmd_imm = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {rEn, wEn, loadBus, done, err, index, busVal, rd_data}, 64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_done", done, 0);

        // LDI r3=20: write strobe at accept+2.
        cmd_op = OP_LDI; cmd_dst = 4'd3; cmd_imm = 16'd20; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ldi_c1_wen", wEn, 0);
        chk("ldi_c1_load", loadBus, 1);
        @(negedge clk);
        chk("ldi_c2_ctrl", {wEn, index, busVal}, {1'b1, 4'd3, 16'd20});
        @(negedge clk);
        chk("ldi_c3_done", {done, err}, 2'b10);
        model(OP_LDI, 4'd0, 4'd3, 16'd20, mlat, me, mrv);
        run_cmd(OP_RD, 4'd3, 4'd0, 16'h0, lat, e, rv);
        model(OP_RD, 4'd3, 4'd0, 16'h0, mlat, me, mrv);
        chk("rd3_lat", lat, 3);
        chk("rd3_data", rv, 16'd20);

        // Reset during DRV of a MOV aborts it with no write and no done.
        run_cmd(OP_LDI, 4'd0, 4'd9, 16'hBEEF, lat, e, rv);
        model(OP_LDI, 4'd0, 4'd9, 16'hBEEF, mlat, me, mrv);
        cmd_op = OP_MOV; cmd_src = 4'd9; cmd_dst = 4'd10; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mov_drv_load", loadBus, 1);
        w0 = wen_cnt; d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk("abort_outputs",
            {rEn, wEn, loadBus, done, err, index, busVal, rd_data}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_wen", wen_cnt - w0, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_ready", cmd_ready, 1);
        m_rd = 16'h0;
        run_cmd(OP_RD, 4'd10, 4'd0, 16'h0, lat, e, rv);
        model(OP_RD, 4'd10, 4'd0, 16'h0, mlat, me, mrv);
        chk("abort_r10", rv, 16'h0);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_cmd(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].imm, lat, e, rv);
            model(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].imm, mlat, me, mrv);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].err);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), rv, tbl[i].rd);
        end

        // Three LDIs with cmd_valid held high.
        w0 = wen_cnt;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int g;
            cmd_op = OP_LDI;
            cmd_dst = 4'd11 + 4'(k);
            cmd_imm = 16'hA000 + 16'(k);
            g = 0;
            while (!cmd_ready && g < 20) begin @(negedge clk); g++; end
            if (k > 0) chk($sformatf("b2b%0d_done_accept", k), done, 1);
            @(negedge clk);
            model(OP_LDI, 4'd0, 4'd11 + 4'(k), 16'hA000 + 16'(k), mlat, me, mrv);
        end
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        chk("b2b_last_lat", lat, 3);
        chk("b2b_writes", wen_cnt - w0, 3);

        // Random commands against the model.
        for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            logic [3:0] s, d;
            logic [15:0] imm;
            op = 2'($urandom_range(0, 3));
            s = 4'($urandom);
            d = 4'($urandom);
            imm = 16'($urandom);
            run_cmd(op, s, d, imm, lat, e, rv);
            model(op, s, d, imm, mlat, me, mrv);
            chk($sformatf("rnd%0d_lat", n), lat, mlat);
            chk($sformatf("rnd%0d_err", n), e, me);
            if (op == OP_RD) chk($sformatf("rnd%0d_rd", n), rv, mrv);
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("final_r%0d", i), rf[i], m[i]);
        end
        chk("invariants", mon_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
